fmc_adc_pattern_gen: RTL and testbench

//  Parametrised multi-channel ADC stimulus source; generalises the ad-hoc per-channel data/valid generation used in FMC ADC benches.

---
 rtl/fmc_adc_pattern_gen_pkg.sv | 36 +++
 rtl/fmc_adc_pattern_gen_lfsr.sv | 23 ++
 rtl/fmc_adc_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_fmc_adc_pattern_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmc_adc_pattern_gen_pkg.sv
// Shared definitions for the FMC ADC pattern generator.
// Mode codes, FSM states, LFSR taps/seeds, rotate helper.
package fmc_adc_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'b00,
    MODE_LFSR   = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_CONST  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Right-shift Galois masks.
  // x^32+x^22+x^2+x+1 and x^8+x^6+x^5+x^4+1.
  localparam logic [31:0] DATA_TAPS  = 32'h8020_0003;
  localparam logic [7:0]  VALID_TAPS = 8'hB8;

  localparam logic [31:0] DEF_DATA_SEED  = 32'hACE1_2468;
  localparam logic [7:0]  DEF_VALID_SEED = 8'h5A;

  function automatic logic [31:0] rotl32(
    input logic [31:0] v,
    input int unsigned n
  );
    int unsigned s;
    s = n % 32;
    if (s == 0) return v;
    return (v << s) | (v >> (32 - s));
  endfunction

endpackage

// File: rtl/fmc_adc_pattern_gen_lfsr.sv
// Generic right-shift Galois LFSR (module lfsr_galois).
// Ports: clk, reload (sync, loads SEED), step, state.
module lfsr_galois #(
  parameter int unsigned     WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = '1,
  parameter logic [WIDTH-1:0] SEED = '1
) (
  input  logic             clk,
  input  logic             reload,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk) begin
    if (reload) begin
      state <= SEED;
    end else if (step) begin
      state <= {1'b0, state[WIDTH-1:1]}
             ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/fmc_adc_pattern_gen.sv
// N-channel ADC stimulus: ramp/lfsr/toggle/const with
// LFSR-throttled valid. Ports: sys_clk_i, sys_rst_i, cfg_*,
// adc_data_o/_n_o, adc_valid_o, sample_cnt_o, busy_o.
// Optional burst mode: define ADC_PATGEN_BURST_EN.
module fmc_adc_pattern_gen
  import fmc_adc_pattern_gen_pkg::*;
#(
  parameter int unsigned g_num_channels = 4,
  parameter int unsigned g_data_width   = 16,
  parameter logic [31:0] g_seed         = DEF_DATA_SEED
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic                      cfg_en_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [g_data_width-1:0]   cfg_start_val_i,
  input  logic [g_data_width-1:0]   cfg_step_i,
  input  logic [7:0]                cfg_valid_thresh_i,
  input  logic [31:0]               cfg_burst_len_i,
  output logic [g_num_channels*g_data_width-1:0] adc_data_o,
  output logic [g_num_channels*g_data_width-1:0] adc_data_n_o,
  output logic                      adc_valid_o,
  output logic [31:0]               sample_cnt_o,
  output logic                      busy_o
);

  localparam int unsigned N = g_num_channels;
  localparam int unsigned W = g_data_width;

  state_e         state;
  mode_e          mode_q;
  logic [W-1:0]   step_q;
  logic [7:0]     thresh_q;
  logic [7:0]     rnd8;
  logic [31:0]    dstate;
  logic           start;
  logic           run;
  logic           ok;
  logic           fire;
  logic           reload;
  logic [N*W-1:0] bus_nxt;

`ifdef ADC_PATGEN_BURST_EN
  logic [31:0]    burst_q;
`else
  logic           unused_burst;
  assign unused_burst = ^cfg_burst_len_i;
`endif

  assign start  = (state == ST_IDLE) && cfg_en_i;
  assign run    = (state == ST_RUN);
  assign ok     = (thresh_q == 8'd0) || (rnd8 >= thresh_q);
  assign fire   = run && cfg_en_i && ok;
  // Keep both LFSRs at seed while idle so every start
  // replays the same sequences.
  assign reload = sys_rst_i || (state == ST_IDLE);
  assign busy_o = (state != ST_IDLE);

  lfsr_galois #(
    .WIDTH (8),
    .TAPS  (VALID_TAPS),
    .SEED  (DEF_VALID_SEED)
  ) u_valid_lfsr (
    .clk    (sys_clk_i),
    .reload (reload),
    .step   (run),
    .state  (rnd8)
  );

  lfsr_galois #(
    .WIDTH (32),
    .TAPS  (DATA_TAPS),
    .SEED  (g_seed)
  ) u_data_lfsr (
    .clk    (sys_clk_i),
    .reload (reload),
    .step   (fire && (mode_q == MODE_LFSR)),
    .state  (dstate)
  );

  for (genvar k = 0; k < N; k++) begin : g_ch
    logic [W-1:0]  pat;
    logic [31:0]   rot;
    logic [W-1:0]  cur;

    assign rot = rotl32(dstate, 4 * k);
    assign cur = (mode_q == MODE_LFSR) ? rot[W-1:0] : pat;
    assign bus_nxt[k*W +: W] = cur;

    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        pat <= '0;
      end else if (start) begin
        if (cfg_mode_i == MODE_RAMP)
          pat <= cfg_start_val_i + W'(k);
        else
          pat <= cfg_start_val_i;
      end else if (fire) begin
        unique case (1'b1)
          mode_q == MODE_RAMP:   pat <= pat + step_q;
          mode_q == MODE_TOGGLE: pat <= ~pat;
          default:               pat <= pat;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_RAMP;
      step_q       <= '0;
      thresh_q     <= '0;
      adc_data_o   <= '0;
      adc_data_n_o <= '1;
      adc_valid_o  <= 1'b0;
      sample_cnt_o <= '0;
`ifdef ADC_PATGEN_BURST_EN
      burst_q      <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          adc_valid_o <= 1'b0;
          if (cfg_en_i) begin
            state        <= ST_RUN;
            mode_q       <= mode_e'(cfg_mode_i);
            step_q       <= cfg_step_i;
            thresh_q     <= cfg_valid_thresh_i;
            sample_cnt_o <= '0;
`ifdef ADC_PATGEN_BURST_EN
            burst_q      <= cfg_burst_len_i;
`endif
          end
        end
        ST_RUN: begin
          if (!cfg_en_i) begin
            state       <= ST_IDLE;
            adc_valid_o <= 1'b0;
          end else if (ok) begin
            adc_data_o   <= bus_nxt;
            adc_data_n_o <= ~bus_nxt;
            adc_valid_o  <= 1'b1;
            sample_cnt_o <= sample_cnt_o + 32'd1;
`ifdef ADC_PATGEN_BURST_EN
            if (burst_q != 32'd0 &&
                sample_cnt_o + 32'd1 == burst_q)
              state <= ST_DONE;
`endif
          end else begin
            adc_valid_o <= 1'b0;
          end
        end
        ST_DONE: begin
          adc_valid_o <= 1'b0;
          if (!cfg_en_i) state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          adc_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmc_adc_pattern_gen.sv
// Directed self-checking bench for fmc_adc_pattern_gen.
// Default config: 4 channels x 16 bits, default seed.
module tb_fmc_adc_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] start_val;
  logic [15:0] step;
  logic [7:0]  thresh;
  logic [31:0] burst_len;
  logic [63:0] dout;
  logic [63:0] dout_n;
  logic        valid;
  logic [31:0] cnt;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fmc_adc_pattern_gen dut (
    .sys_clk_i          (clk),
    .sys_rst_i          (rst),
    .cfg_en_i           (en),
    .cfg_mode_i         (mode),
    .cfg_start_val_i    (start_val),
    .cfg_step_i         (step),
    .cfg_valid_thresh_i (thresh),
    .cfg_burst_len_i    (burst_len),
    .adc_data_o         (dout),
    .adc_data_n_o       (dout_n),
    .adc_valid_o        (valid),
    .sample_cnt_o       (cnt),
    .busy_o             (busy)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stop, load config, enable; returns just after the
  // RUN entry edge.
  task automatic start_run(
    input logic [1:0]  m,
    input logic [15:0] sv,
    input logic [15:0] st,
    input logic [7:0]  th
  );
    en = 1'b0;
    tick();
    mode      = m;
    start_val = sv;
    step      = st;
    thresh    = th;
    en        = 1'b1;
    tick();
  endtask

  logic [63:0] seq_a [64];
  int          pulses;
  int          bad;

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    mode      = 2'b00;
    start_val = '0;
    step      = '0;
    thresh    = '0;
    burst_len = '0;
    tick();
    tick();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data", dout, 64'd0);
    check("rst_data_n", dout_n, {64{1'b1}});
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Ramp from 0, step 1
    start_run(2'b00, 16'h0000, 16'h0001, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ramp_valid", 64'(valid), 64'd1);
      check("ramp_ch0", 64'(dout[15:0]), 64'(i));
      check("ramp_ch3", 64'(dout[63:48]), 64'(i + 3));
    end
    check("ramp_cnt", 64'(cnt), 64'd6);
    check("ramp_busy", 64'(busy), 64'd1);

    // Ramp wrap
    start_run(2'b00, 16'hFFFE, 16'h0001, 8'h00);
    tick();
    check("wrap_s0", dout, 64'h0001_0000_FFFF_FFFE);
    tick();
    check("wrap_s1", dout, 64'h0002_0001_0000_FFFF);
    tick();
    check("wrap_s2", dout, 64'h0003_0002_0001_0000);
    check("wrap_cnt", 64'(cnt), 64'd3);

    // Toggle; mid-run config changes must not apply
    start_run(2'b10, 16'h00FF, 16'h0000, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) begin
        mode      = 2'b00;
        start_val = 16'h1234;
        step      = 16'h0005;
      end
      check("tog_data", dout,
            (i % 2 == 0) ? 64'h00FF_00FF_00FF_00FF
                         : 64'hFF00_FF00_FF00_FF00);
      check("tog_n", dout_n,
            (i % 2 == 0) ? 64'hFF00_FF00_FF00_FF00
                         : 64'h00FF_00FF_00FF_00FF);
    end

    // Constant with ~50% valid throttle
    start_run(2'b11, 16'h1234, 16'h0000, 8'h80);
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (valid) begin
        pulses++;
        if (dout !== 64'h1234_1234_1234_1234) bad++;
      end
      if (dout_n !== ~dout) bad++;
    end
    check("thr_cnt", 64'(cnt), 64'(pulses));
    check("thr_data_bad", 64'(bad), 64'd0);
    check("thr_ratio",
          64'(pulses >= 4500 && pulses <= 5500), 64'd1);

    // LFSR mode: hand-computed first samples, then replay
    start_run(2'b01, 16'h0000, 16'h0000, 8'h00);
    for (int i = 0; i < 64; i++) begin
      tick();
      seq_a[i] = dout;
      check("lfsr_nz", 64'(dout != 64'd0), 64'd1);
      if (i == 0)
        check("lfsr_s0", dout, 64'h8ACE_68AC_468A_2468);
      if (i == 1)
        check("lfsr_s1_ch0", 64'(dout[15:0]), 64'h9234);
    end
    start_run(2'b01, 16'h0000, 16'h0000, 8'h00);
    for (int i = 0; i < 64; i++) begin
      tick();
      check("lfsr_replay", dout, seq_a[i]);
    end

    // Stop clears valid at that edge
    en = 1'b0;
    tick();
    check("stop_valid", 64'(valid), 64'd0);
    check("stop_busy", 64'(busy), 64'd0);

    // Reset mid-run, then restart ramp
    start_run(2'b00, 16'h0000, 16'h0001, 8'h00);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mrst_valid", 64'(valid), 64'd0);
    check("mrst_data", dout, 64'd0);
    check("mrst_data_n", dout_n, {64{1'b1}});
    check("mrst_cnt", 64'(cnt), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    check("rerun_s0", dout, 64'h0003_0002_0001_0000);
    tick();
    check("rerun_s1", dout, 64'h0004_0003_0002_0001);

`ifdef ADC_PATGEN_BURST_EN
    burst_len = 32'd5;
    start_run(2'b00, 16'h0010, 16'h0001, 8'h00);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 3) start_val = 16'h0100;
      if (valid) pulses++;
    end
    check("burst_pulses", 64'(pulses), 64'd5);
    check("burst_cnt", 64'(cnt), 64'd5);
    check("burst_busy", 64'(busy), 64'd1);
    check("burst_last", 64'(dout[15:0]), 64'h0014);
    en = 1'b0;
    tick();
    check("burst_idle", 64'(busy), 64'd0);
    en = 1'b1;
    tick();
    tick();
    check("burst_newcfg", 64'(dout[15:0]), 64'h0100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
